// File: rtl/intc_pkg.sv
// Shared types and defaults for the interrupt controller.
// Build option: INTC_SYNC_EN adds a 2-flop irq synchroniser.
package intc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACK     = 2'd1,
    ST_SERVICE = 2'd2
  } intc_state_e;

  localparam int VEC_BASE_DEF   = 'h3C0;
  localparam int VEC_STRIDE_DEF = 8;

  function automatic int intc_idw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/intc_prio_enc.sv
// Fixed-priority encoder: lowest set index wins.
// Purely combinational; used by interrupt_ctrl.
module intc_prio_enc
  import intc_pkg::*;
#(
  parameter int NSRC = 4,
  parameter int IDW  = intc_idw(NSRC)
) (
  input  logic [NSRC-1:0] req_i,
  output logic            valid_o,
  output logic [IDW-1:0]  id_o
);

  always_comb begin
    id_o = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req_i[i]) id_o = IDW'(i);
    end
  end

  assign valid_o = |req_i;

endmodule

// File: rtl/interrupt_ctrl.sv
// Interrupt controller: edge-latched requests, mask, priority, EOI handshake.
// Build option: INTC_SYNC_EN inserts a 2-flop synchroniser on irq.
module interrupt_ctrl
  import intc_pkg::*;
#(
  parameter int            NSRC       = 4,
  parameter int            AW         = 10,
  parameter logic [AW-1:0] VEC_BASE   = AW'(VEC_BASE_DEF),
  parameter int            VEC_STRIDE = VEC_STRIDE_DEF,
  localparam int           IDW        = intc_idw(NSRC)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] irq,
  input  logic            mask_we,
  input  logic [NSRC-1:0] mask_d,
  input  logic            finInterrup,
  output logic            s_interrup,
  output logic [AW-1:0]   vector,
  output logic            in_service,
  output logic [IDW-1:0]  active_id,
  output logic [NSRC-1:0] pending
);

  logic [NSRC-1:0] irq_s;

`ifdef INTC_SYNC_EN
  logic [NSRC-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq;
      sync2_q <= sync1_q;
    end
  end

  assign irq_s = sync2_q;
`else
  assign irq_s = irq;
`endif

  intc_state_e     state_q, state_d;
  logic [NSRC-1:0] irq_q;
  logic [NSRC-1:0] mask_q, mask_dn;
  logic [NSRC-1:0] pend_q, pend_d;
  logic [NSRC-1:0] clr;
  logic [NSRC-1:0] rise;
  logic            sint_q, sint_d;
  logic            svc_q, svc_d;
  logic [AW-1:0]   vec_q, vec_d;
  logic [IDW-1:0]  id_q, id_d;
  logic            win_vld;
  logic [IDW-1:0]  win_id;

  assign rise    = irq_s & ~irq_q;
  assign mask_dn = mask_we ? mask_d : mask_q;

  intc_prio_enc #(
    .NSRC (NSRC),
    .IDW  (IDW)
  ) u_prio (
    .req_i   (pend_q & mask_q),
    .valid_o (win_vld),
    .id_o    (win_id)
  );

  always_comb begin
    state_d = state_q;
    sint_d  = 1'b0;
    svc_d   = svc_q;
    vec_d   = vec_q;
    id_d    = id_q;
    clr     = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (win_vld) begin
          state_d     = ST_ACK;
          sint_d      = 1'b1;
          svc_d       = 1'b1;
          id_d        = win_id;
          vec_d       = VEC_BASE + AW'(win_id) * AW'(VEC_STRIDE);
          clr[win_id] = 1'b1;
        end
      end
      ST_ACK: state_d = ST_SERVICE;
      ST_SERVICE: begin
        if (finInterrup) begin
          state_d = ST_IDLE;
          svc_d   = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        svc_d   = 1'b0;
      end
    endcase
    // a fresh edge on the source being accepted must not be lost
    pend_d = (pend_q & ~clr) | rise;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      irq_q   <= '0;
      mask_q  <= '0;
      pend_q  <= '0;
      sint_q  <= 1'b0;
      svc_q   <= 1'b0;
      vec_q   <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      irq_q   <= irq_s;
      mask_q  <= mask_dn;
      pend_q  <= pend_d;
      sint_q  <= sint_d;
      svc_q   <= svc_d;
      vec_q   <= vec_d;
      id_q    <= id_d;
    end
  end

  assign s_interrup = sint_q;
  assign vector     = vec_q;
  assign in_service = svc_q;
  assign active_id  = id_q;
  assign pending    = pend_q;

endmodule
